// File: rtl/output_tile_scheduler_pkg.sv
// Shared definitions for the output tile scheduler: the default geometry,
// the derived width constants and the sequencing state encoding.
package output_tile_scheduler_pkg;

  localparam int DEF_MAX_OUT_ROWS = 128;
  localparam int DEF_MAX_OUT_COLS = 128;
  localparam int DEF_SYS_ARR_ROWS = 16;
  localparam int DEF_SYS_ARR_COLS = 16;
  localparam int DEF_ADDR_WIDTH   = 8;

  // Tile grid dimensions for the default geometry
  localparam int NUM_SUBMATS_M = DEF_MAX_OUT_ROWS / DEF_SYS_ARR_ROWS;
  localparam int NUM_SUBMATS_N = DEF_MAX_OUT_COLS / DEF_SYS_ARR_COLS;

  // Field widths for the default geometry
  localparam int RW = $clog2(DEF_MAX_OUT_ROWS);
  localparam int CW = $clog2(DEF_MAX_OUT_COLS);
  localparam int MW = $clog2(NUM_SUBMATS_M);
  localparam int NW = $clog2(NUM_SUBMATS_N);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/output_tile_scheduler_if.sv
// Command and output-controller signals of the tile scheduler.
// master: the scheduler itself; slave: the sequencer/controller side.
interface output_tile_scheduler_if
  import output_tile_scheduler_pkg::*;
#(
  parameter int MAX_OUT_ROWS = DEF_MAX_OUT_ROWS,
  parameter int MAX_OUT_COLS = DEF_MAX_OUT_COLS,
  parameter int SYS_ARR_ROWS = DEF_SYS_ARR_ROWS,
  parameter int SYS_ARR_COLS = DEF_SYS_ARR_COLS,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH
);
  localparam int ROW_W  = $clog2(MAX_OUT_ROWS);
  localparam int COL_W  = $clog2(MAX_OUT_COLS);
  localparam int SUBR_W = $clog2(MAX_OUT_ROWS / SYS_ARR_ROWS);
  localparam int SUBC_W = $clog2(MAX_OUT_COLS / SYS_ARR_COLS);
  localparam int TR_W   = $clog2(SYS_ARR_ROWS);
  localparam int TC_W   = $clog2(SYS_ARR_COLS);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ROW_W-1:0]      cfg_rows_m1;
  logic [COL_W-1:0]      cfg_cols_m1;
  logic [ADDR_WIDTH-1:0] cfg_base_addr;
  logic                  cfg_clear_after;
  logic                  cfg_activate;
  logic                  cmd_done;
  logic                  oc_start;
  logic                  oc_done;
  logic [SUBR_W-1:0]     oc_submat_row;
  logic [SUBC_W-1:0]     oc_submat_col;
  logic [TR_W-1:0]       oc_num_rows_read;
  logic [TC_W-1:0]       oc_num_cols_read;
  logic [ADDR_WIDTH-1:0] oc_wr_base_addr;
  logic                  oc_clear_after;
  logic                  oc_activate;

  modport master (
    input  cmd_valid, cfg_rows_m1, cfg_cols_m1, cfg_base_addr,
           cfg_clear_after, cfg_activate, oc_done,
    output cmd_ready, cmd_done, oc_start, oc_submat_row, oc_submat_col,
           oc_num_rows_read, oc_num_cols_read, oc_wr_base_addr,
           oc_clear_after, oc_activate
  );

  modport slave (
    output cmd_valid, cfg_rows_m1, cfg_cols_m1, cfg_base_addr,
           cfg_clear_after, cfg_activate, oc_done,
    input  cmd_ready, cmd_done, oc_start, oc_submat_row, oc_submat_col,
           oc_num_rows_read, oc_num_cols_read, oc_wr_base_addr,
           oc_clear_after, oc_activate
  );

endinterface

// File: rtl/output_tile_scheduler_submat_tile_counter.sv
// Two-dimensional row/col tile counter. Column is the inner index and wraps
// at last_col, bumping the row. last_tile flags the final tile of the grid.
module submat_tile_counter #(
  parameter int ROW_W = 3,
  parameter int COL_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  input  logic [ROW_W-1:0] last_row,
  input  logic [COL_W-1:0] last_col,
  output logic [ROW_W-1:0] nxt_row,
  output logic [COL_W-1:0] nxt_col,
  output logic             last_tile
);
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;

  // Successor tile position and end-of-grid detection
  always_comb begin
    last_tile = (row == last_row) && (col == last_col);
    nxt_row   = row;
    nxt_col   = col + COL_W'(1);
    if (col == last_col) begin
      nxt_col = '0;
      nxt_row = row + ROW_W'(1);
    end
  end

  // Position register: cleared on a new command, stepped once per finished tile
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      row <= nxt_row;
      col <= nxt_col;
    end
  end

endmodule

// File: rtl/output_tile_scheduler.sv
// Walks the output controller over every tile of one output matrix: latches a
// command, issues each tile with edge-trimmed counts and its write address,
// waits for the controller to finish, and pulses cmd_done after the last tile.
module output_tile_scheduler
  import output_tile_scheduler_pkg::*;
#(
  parameter int MAX_OUT_ROWS = DEF_MAX_OUT_ROWS,
  parameter int MAX_OUT_COLS = DEF_MAX_OUT_COLS,
  parameter int SYS_ARR_ROWS = DEF_SYS_ARR_ROWS,
  parameter int SYS_ARR_COLS = DEF_SYS_ARR_COLS,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  output_tile_scheduler_if.master bus
);
  localparam int ROW_W  = $clog2(MAX_OUT_ROWS);
  localparam int COL_W  = $clog2(MAX_OUT_COLS);
  localparam int SUBR_W = $clog2(MAX_OUT_ROWS / SYS_ARR_ROWS);
  localparam int SUBC_W = $clog2(MAX_OUT_COLS / SYS_ARR_COLS);
  localparam int TR_W   = $clog2(SYS_ARR_ROWS);
  localparam int TC_W   = $clog2(SYS_ARR_COLS);
  localparam int MUL_W  = SUBC_W + ROW_W + 1;

  state_t                state, state_nxt;
  logic                  accept;
  logic                  advance;
  logic                  last_tile;

  logic [ROW_W-1:0]      rows_m1_q;
  logic [COL_W-1:0]      cols_m1_q;
  logic [ADDR_WIDTH-1:0] base_q;

  logic [SUBR_W-1:0]     nxt_row;
  logic [SUBC_W-1:0]     nxt_col;

  logic [ROW_W-1:0]      src_rows;
  logic [COL_W-1:0]      src_cols;
  logic [ADDR_WIDTH-1:0] src_base;
  logic [SUBR_W-1:0]     tile_row;
  logic [SUBC_W-1:0]     tile_col;
  logic [TR_W-1:0]       tile_nrows;
  logic [TC_W-1:0]       tile_ncols;
  logic [MUL_W-1:0]      col_off;
  logic [SUBR_W+TR_W-1:0] row_off;
  logic [ADDR_WIDTH-1:0] tile_addr;

  assign accept = bus.cmd_valid & bus.cmd_ready;

  submat_tile_counter #(
    .ROW_W (SUBR_W),
    .COL_W (SUBC_W)
  ) u_tile_cnt (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept),
    .advance   (advance),
    .last_row  (rows_m1_q[ROW_W-1:TR_W]),
    .last_col  (cols_m1_q[COL_W-1:TC_W]),
    .nxt_row   (nxt_row),
    .nxt_col   (nxt_col),
    .last_tile (last_tile)
  );

  // Sequencing: one ISSUE cycle per tile, then WAIT for the controller
  always_comb begin
    state_nxt = state;
    advance   = 1'b0;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_ISSUE;
      S_ISSUE:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.oc_done) begin
          if (last_tile) begin
            state_nxt = S_FINISH;
          end else begin
            state_nxt = S_ISSUE;
            advance   = 1'b1;
          end
        end
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Fields of the tile about to be issued. On accept the configuration is
  // still on the cfg_* inputs, so the first tile is built from them directly.
  always_comb begin
    src_rows = (state == S_IDLE) ? bus.cfg_rows_m1   : rows_m1_q;
    src_cols = (state == S_IDLE) ? bus.cfg_cols_m1   : cols_m1_q;
    src_base = (state == S_IDLE) ? bus.cfg_base_addr : base_q;
    tile_row = (state == S_IDLE) ? '0 : nxt_row;
    tile_col = (state == S_IDLE) ? '0 : nxt_col;

    tile_nrows = (tile_row == src_rows[ROW_W-1:TR_W]) ? src_rows[TR_W-1:0]
                                                      : TR_W'(SYS_ARR_ROWS - 1);
    tile_ncols = (tile_col == src_cols[COL_W-1:TC_W]) ? src_cols[TC_W-1:0]
                                                      : TC_W'(SYS_ARR_COLS - 1);

    // Tiles are stored column-block major: each column block spans rows_m1+1
    // entries, and each tile row inside it is SYS_ARR_ROWS entries further on.
    col_off   = MUL_W'(tile_col) * (MUL_W'(src_rows) + MUL_W'(1));
    row_off   = {tile_row, {TR_W{1'b0}}};
    tile_addr = src_base + ADDR_WIDTH'(col_off) + ADDR_WIDTH'(row_off);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Command latch: configuration is captured once per accepted command
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_m1_q          <= '0;
      cols_m1_q          <= '0;
      base_q             <= '0;
      bus.oc_clear_after <= 1'b0;
      bus.oc_activate    <= 1'b0;
    end else if (accept) begin
      rows_m1_q          <= bus.cfg_rows_m1;
      cols_m1_q          <= bus.cfg_cols_m1;
      base_q             <= bus.cfg_base_addr;
      bus.oc_clear_after <= bus.cfg_clear_after;
      bus.oc_activate    <= bus.cfg_activate;
    end
  end

  // Registered outputs; tile fields load on entry to ISSUE and hold after
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.cmd_ready        <= 1'b1;
      bus.cmd_done         <= 1'b0;
      bus.oc_start         <= 1'b0;
      bus.oc_submat_row    <= '0;
      bus.oc_submat_col    <= '0;
      bus.oc_num_rows_read <= '0;
      bus.oc_num_cols_read <= '0;
      bus.oc_wr_base_addr  <= '0;
    end else begin
      bus.cmd_ready <= (state_nxt == S_IDLE);
      bus.cmd_done  <= (state_nxt == S_FINISH);
      bus.oc_start  <= (state_nxt == S_ISSUE);
      if (state_nxt == S_ISSUE) begin
        bus.oc_submat_row    <= tile_row;
        bus.oc_submat_col    <= tile_col;
        bus.oc_num_rows_read <= tile_nrows;
        bus.oc_num_cols_read <= tile_ncols;
        bus.oc_wr_base_addr  <= tile_addr;
      end
    end
  end

endmodule

// File: tb/tb_output_tile_scheduler.sv
// Bench for output_tile_scheduler: a behavioural output controller, a
// queue-based scoreboard fed at command issue, and a monitor on the DUT outputs.
module tb_output_tile_scheduler;

  logic clk;
  logic reset;
  int   cyc;
  int   tests;
  int   fails;
  int   starts_seen;
  bit   chk_ready_next;
  int   oc_cnt;

  typedef struct {
    int row;
    int col;
    int nrows;
    int ncols;
    int addr;
    int clr;
    int act;
    int cyc;
  } tile_t;

  tile_t exp_q[$];
  int    done_q[$];
  tile_t mon_e;
  int    mon_d;

  output_tile_scheduler_if bus ();

  output_tile_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: enumerate tiles row-major with plain arithmetic and
  // predict each start cycle from the controller's busy time.
  task automatic push_cmd(input int rm, input int cm, input int base,
                          input int clr, input int act, input int x);
    int    n_tr, n_tc, t;
    tile_t e;
    n_tr = rm / 16 + 1;
    n_tc = cm / 16 + 1;
    t    = x;
    for (int r = 0; r < n_tr; r++) begin
      for (int c = 0; c < n_tc; c++) begin
        e.row   = r;
        e.col   = c;
        e.nrows = ((rm + 1 - r * 16) < 16 ? (rm + 1 - r * 16) : 16) - 1;
        e.ncols = ((cm + 1 - c * 16) < 16 ? (cm + 1 - c * 16) : 16) - 1;
        e.addr  = (base + c * (rm + 1) + r * 16) % 256;
        e.clr   = clr;
        e.act   = act;
        e.cyc   = t;
        exp_q.push_back(e);
        t = t + e.nrows + 3;
      end
    end
    done_q.push_back(t);
  endtask

  task automatic run_cmd(input int rm, input int cm, input int base,
                         input int clr, input int act, input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (bus.cmd_ready !== 1'b1) begin
      tests = tests + 1;
      fails = fails + 1;
      $display("FAIL ready_timeout: got cmd_ready=%b, required 1", bus.cmd_ready);
      return;
    end
    bus.cfg_rows_m1     = 7'(rm);
    bus.cfg_cols_m1     = 7'(cm);
    bus.cfg_base_addr   = 8'(base);
    bus.cfg_clear_after = clr[0];
    bus.cfg_activate    = act[0];
    bus.cmd_valid       = 1'b1;
    @(posedge clk);
    #1;
    push_cmd(rm, cm, base, clr, act, cyc);
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_tiles_left", exp_q.size(), 0);
    chk("drain_dones_left", done_q.size(), 0);
  endtask

  // Output controller model: done drops the cycle after start and rises
  // num_rows_read+2 cycles after start.
  always @(negedge clk) begin
    if (reset) begin
      bus.oc_done = 1'b1;
      oc_cnt      = 0;
    end else if (bus.oc_start) begin
      bus.oc_done = 1'b0;
      oc_cnt      = int'(bus.oc_num_rows_read) + 2;
    end else if (oc_cnt > 0) begin
      oc_cnt = oc_cnt - 1;
      if (oc_cnt == 0) bus.oc_done = 1'b1;
    end
  end

  // Monitor: compare every start and every cmd_done against the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.oc_start) begin
        starts_seen = starts_seen + 1;
        if (exp_q.size() == 0) begin
          tests = tests + 1;
          fails = fails + 1;
          $display("FAIL unexpected_start: got start at cycle %0d, required none", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("start_cycle", cyc, mon_e.cyc);
          chk("tile_row", bus.oc_submat_row, mon_e.row);
          chk("tile_col", bus.oc_submat_col, mon_e.col);
          chk("num_rows_read", bus.oc_num_rows_read, mon_e.nrows);
          chk("num_cols_read", bus.oc_num_cols_read, mon_e.ncols);
          chk("wr_base_addr", bus.oc_wr_base_addr, mon_e.addr);
          chk("clear_after", bus.oc_clear_after, mon_e.clr);
          chk("activate", bus.oc_activate, mon_e.act);
          chk("ready_while_busy", bus.cmd_ready, 0);
        end
      end
      if (bus.cmd_done) begin
        if (done_q.size() == 0) begin
          tests = tests + 1;
          fails = fails + 1;
          $display("FAIL unexpected_done: got cmd_done at cycle %0d, required none", cyc);
        end else begin
          mon_d = done_q.pop_front();
          chk("done_cycle", cyc, mon_d);
          chk("ready_in_finish", bus.cmd_ready, 0);
        end
        chk_ready_next = 1'b1;
      end else if (chk_ready_next) begin
        chk("ready_after_done", bus.cmd_ready, 1);
        chk_ready_next = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish by time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0, n;
    cyc             = 0;
    tests           = 0;
    fails           = 0;
    starts_seen     = 0;
    chk_ready_next  = 1'b0;
    reset           = 1'b1;
    bus.cmd_valid       = 1'b0;
    bus.cfg_rows_m1     = '0;
    bus.cfg_cols_m1     = '0;
    bus.cfg_base_addr   = '0;
    bus.cfg_clear_after = 1'b0;
    bus.cfg_activate    = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_oc_start", bus.oc_start, 0);
    chk("rst_cmd_done", bus.cmd_done, 0);
    chk("rst_addr", bus.oc_wr_base_addr, 0);
    chk("rst_clear_after", bus.oc_clear_after, 0);
    reset = 1'b0;

    // Directed cases
    run_cmd(4, 2, 8'h10, 1, 0, 0);    // single partial tile
    run_cmd(31, 31, 0, 0, 1, 0);      // 2x2 full tiles
    run_cmd(19, 35, 8'h05, 1, 1, 0);  // edge trim, 2x3 tiles
    run_cmd(15, 31, 250, 0, 0, 0);    // address wrap
    drain();

    // cmd_valid held across a busy command, then a second command
    run_cmd(5, 5, 1, 0, 1, 1);
    run_cmd(0, 0, 8'h80, 1, 0, 0);
    drain();

    // Randomised commands
    for (int i = 0; i < 10; i++) begin
      run_cmd(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
              int'($urandom_range(0, 1)), 0);
    end
    drain();

    // Reset while waiting on tile (1,0) of a 2x2 command
    s0 = starts_seen;
    run_cmd(31, 31, 8'h20, 1, 1, 0);
    n = 0;
    while (starts_seen < s0 + 3 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("reset_test_reached_tile", starts_seen - s0, 3);
    @(posedge clk);
    #2;
    reset = 1'b1;
    exp_q.delete();
    done_q.delete();
    chk_ready_next = 1'b0;
    #1;
    chk("midrst_oc_start", bus.oc_start, 0);
    chk("midrst_cmd_ready", bus.cmd_ready, 1);
    chk("midrst_row", bus.oc_submat_row, 0);
    chk("midrst_addr", bus.oc_wr_base_addr, 0);
    chk("midrst_activate", bus.oc_activate, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_cmd(20, 40, 8'h33, 0, 1, 0);
    drain();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
